// File: rtl/jacobi_accum_engine.sv
// jacobi_accum_engine: one Jacobi sweep over an N-row vector held in a
// ping-pong V SRAM. Each new word is (y[i] + v[i-1] + v[i+1]) >>> 2, which is
// the update for a tridiagonal system with diagonal 4 and off-diagonals -1.
// The current vector is read from the latched section and the result is
// written to the opposite section, one row per cycle.
module jacobi_accum_engine #(
   parameter int N  = 16,
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_enableAccumCalc,
   input  logic          in_vsram_section,
   output logic          op_accumCalcDoneFlag,
   output logic          op_ysram_re,
   output logic [AW-1:0] op_ysram_addr,
   input  logic [DW-1:0] in_ysram_rdata,
   output logic          op_vsram_re,
   output logic [AW:0]   op_vsram_raddr,
   input  logic [DW-1:0] in_vsram_rdata,
   output logic          op_vsram_we,
   output logic [AW:0]   op_vsram_waddr,
   output logic [DW-1:0] op_vsram_wdata
);

   localparam logic [AW+1:0] N_W = (AW+2)'(N);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

   state_t               state;
   logic                 armed;
   logic                 section;
   logic                 rd_valid_d;
   logic [AW-1:0]        rd_idx;
   logic [DW-1:0]        v_prev;
   logic [DW-1:0]        v_cur;
   logic [DW-1:0]        v_next;
   logic [AW+1:0]        idx1;
   logic [AW+1:0]        idx2;
   logic signed [DW+1:0] sum;
   logic signed [DW+1:0] shifted;

   // Look-ahead row indices, one bit wider than needed so N = 2^AW compares cleanly
   always_comb begin
      idx1 = {2'b00, rd_idx} + (AW+2)'(1);
      idx2 = {2'b00, rd_idx} + (AW+2)'(2);
   end

   // Sweep sequencer: start/arm handshake, read issue, write strobe, done pulse, sliding window
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         armed                <= 1'b1;
         section              <= 1'b0;
         rd_valid_d           <= 1'b0;
         rd_idx               <= '0;
         v_prev               <= '0;
         v_cur                <= '0;
         op_accumCalcDoneFlag <= 1'b0;
         op_ysram_re          <= 1'b0;
         op_ysram_addr        <= '0;
         op_vsram_re          <= 1'b0;
         op_vsram_raddr       <= '0;
         op_vsram_we          <= 1'b0;
         op_vsram_waddr       <= '0;
      end else begin
         op_accumCalcDoneFlag <= 1'b0;
         rd_valid_d           <= op_vsram_re;
         // Each returning V word slides the window; v_next is the word on the bus
         if (rd_valid_d) begin
            v_prev <= v_cur;
            v_cur  <= in_vsram_rdata;
         end
         case (state)
            IDLE: begin
               op_ysram_re <= 1'b0;
               op_vsram_re <= 1'b0;
               op_vsram_we <= 1'b0;
               if (!in_enableAccumCalc) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed          <= 1'b0;
                  section        <= in_vsram_section;
                  rd_idx         <= '0;
                  v_prev         <= '0;
                  v_cur          <= '0;
                  op_vsram_re    <= 1'b1;
                  op_vsram_raddr <= {in_vsram_section, {AW{1'b0}}};
                  state          <= PRIME;
               end
            end
            PRIME: begin
               if (!in_enableAccumCalc) begin
                  op_ysram_re <= 1'b0;
                  op_vsram_re <= 1'b0;
                  op_vsram_we <= 1'b0;
                  state       <= IDLE;
               end else begin
                  op_ysram_re   <= 1'b1;
                  op_ysram_addr <= '0;
                  rd_idx        <= '0;
                  if (N_W > (AW+2)'(1)) begin
                     op_vsram_re    <= 1'b1;
                     op_vsram_raddr <= {section, idx1[AW-1:0]};
                  end else begin
                     op_vsram_re <= 1'b0;
                  end
                  state <= RUN;
               end
            end
            RUN: begin
               if (!in_enableAccumCalc) begin
                  op_ysram_re <= 1'b0;
                  op_vsram_re <= 1'b0;
                  op_vsram_we <= 1'b0;
                  state       <= IDLE;
               end else begin
                  // A Y read this cycle means its row is written next cycle
                  op_vsram_we    <= op_ysram_re;
                  op_vsram_waddr <= {~section, op_ysram_addr};
                  if (idx1 < N_W) begin
                     op_ysram_re   <= 1'b1;
                     op_ysram_addr <= idx1[AW-1:0];
                     rd_idx        <= idx1[AW-1:0];
                     if (idx2 < N_W) begin
                        op_vsram_re    <= 1'b1;
                        op_vsram_raddr <= {section, idx2[AW-1:0]};
                     end else begin
                        op_vsram_re <= 1'b0;
                     end
                  end else begin
                     op_ysram_re <= 1'b0;
                     op_vsram_re <= 1'b0;
                  end
                  // Last row is being written and nothing is left in flight
                  if (!op_ysram_re && op_vsram_we) begin
                     op_accumCalcDoneFlag <= 1'b1;
                     state                <= DONE;
                  end
               end
            end
            DONE: begin
               op_ysram_re <= 1'b0;
               op_vsram_re <= 1'b0;
               op_vsram_we <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write datapath: the Y word and right neighbour arrive on the read buses in the
   // write cycle itself, so wdata is formed combinationally and gated by the registered strobe
   always_comb begin
      v_next  = rd_valid_d ? in_vsram_rdata : '0;
      sum     = $signed({{2{in_ysram_rdata[DW-1]}}, in_ysram_rdata})
              + $signed({{2{v_prev[DW-1]}}, v_prev})
              + $signed({{2{v_next[DW-1]}}, v_next});
      shifted = sum >>> 2;
      op_vsram_wdata = op_vsram_we ? shifted[DW-1:0] : '0;
   end

endmodule

// File: doc/jacobi_accum_engine.md
JACOBI_ACCUM_ENGINE -- requirements
Module: jacobi_accum_engine

Interface
REQ-001 Parameter N, default 16: vector length, 1..2^AW.
REQ-002 Parameter AW, default 4: row address width.
REQ-003 Parameter DW, default 16: signed data width of Y and V words.
REQ-004 clock  in  1  single clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_enableAccumCalc  in  1  level start/hold request from the iteration controller.
REQ-007 in_vsram_section  in  1  V SRAM section holding the current vector; the engine writes the other section.
REQ-008 op_accumCalcDoneFlag  out  1  one-cycle pulse when a full sweep is written.
REQ-009 op_ysram_re  out  1  Y SRAM read enable; read data is valid 1 cycle later.
REQ-010 op_ysram_addr  out  AW  Y SRAM row address.
REQ-011 in_ysram_rdata  in  DW  Y SRAM read data.
REQ-012 op_vsram_re  out  1  V SRAM read enable; read data is valid 1 cycle later.
REQ-013 op_vsram_raddr  out  AW+1  V SRAM read address; MSB = latched section.
REQ-014 in_vsram_rdata  in  DW  V SRAM read data.
REQ-015 op_vsram_we  out  1  V SRAM write enable.
REQ-016 op_vsram_waddr  out  AW+1  V SRAM write address; MSB = inverse of latched section.
REQ-017 op_vsram_wdata  out  DW  new V word.

Function
REQ-018 The engine computes v_new[i] = (y[i] + v[i-1] + v[i+1]) >>> 2 for i = 0..N-1, with v[-1] = v[N] = 0. This is a Jacobi sweep for diagonal 4 and off-diagonals -1.
REQ-019 Sum width: DW+2 signed, sign-extended operands; arithmetic shift right by 2 (floor); result truncated to DW; no saturation is needed or applied.
REQ-020 The state machine has four states: IDLE, PRIME, RUN, DONE.
REQ-021 Start is accepted in IDLE when in_enableAccumCalc=1 and armed=1. On acceptance: latch in_vsram_section, clear armed, go to PRIME.
REQ-022 armed is set in IDLE whenever in_enableAccumCalc=0. A single held-high enable therefore yields exactly one sweep.
REQ-023 PRIME lasts 1 cycle and issues a V read of row 0.
REQ-024 RUN issues a V read of row i+1 (suppressed when i+1 >= N) together with a Y read of row i, one row per cycle.
REQ-025 RUN holds a 3-word sliding window (v[i-1], v[i], v[i+1]); out-of-range entries are 0.
REQ-026 Write timing: op_vsram_we=1 for row i exactly at cycle S+3+i, where S is the start-acceptance cycle; writes go to consecutive rows with no gaps.
REQ-027 op_accumCalcDoneFlag=1 for exactly one cycle at S+N+3 (state DONE), then the engine returns to IDLE.
REQ-028 Read addresses never exceed N-1; op_vsram_raddr MSB is never equal to op_vsram_waddr MSB during a sweep.
REQ-029 A change on in_vsram_section after acceptance has no effect until the next start.
REQ-030 Abort: if in_enableAccumCalc falls in PRIME or RUN, go to IDLE on the next edge. No further reads or writes are issued and no done pulse is generated; rows already written remain written.
REQ-031 N=1: a single write at S+3 with both neighbours 0; done at S+4.
REQ-032 All enables are 0 in IDLE and DONE; addresses and data are don't-care whenever their enable is 0.

Reset
REQ-033 On reset=1: state=IDLE, armed=1, latched section=0, window=0, and all outputs 0 (op_accumCalcDoneFlag, op_ysram_re, op_vsram_re, op_vsram_we, addresses, wdata).
REQ-034 Reset asserted mid-sweep: outputs go to 0 asynchronously with no done pulse. After release, a start requires enable=1 (armed is already 1).

Verification
REQ-035 N=4, y={4,8,12,16}, section0 V={0,0,0,0}, section=0, enable held high: writes to rows 1|0..1|3 = {1,2,3,4} at S+3..S+6; done at S+7 only.
REQ-036 Same y, section1 V={1,2,3,4}, section=1: writes to section0 = {1,3,4,4}.
REQ-037 N=1, y={-5}: write -2 (floor) at S+3; done at S+4.
REQ-038 Enable held high for 20 cycles after done: no second sweep. Drop enable for 1 cycle, then raise it: a new sweep starts.
REQ-039 Enable dropped at S+4 (N=4): at most rows 0..1 written, no done pulse, IDLE at S+5.
REQ-040 Reset pulsed at S+5: we/re/done drop to 0 immediately. Restart after release yields correct results per REQ-035.
